// File: rtl/vga_pixel_writer.sv
// vga_pixel_writer: Avalon-MM fed pixel FIFO driving 640x480 VGA timing.
// Registers: 0 push pixel, 1 ctrl (enable / test pattern), 2 status, 3 clear/flush.
// Optional build macro: VGA_PIXEL_WRITER_TEST_PATTERN_EN enables the colour-bar
// test pattern selected by ctrl bit1; without it ctrl bit1 is not stored.
module vga_pixel_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_DIV    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [7:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        BLANK_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          pix_en, sof, active, en_now, pixel_due;

    logic          ctrl_enable, enable_live, ovf_flag, unf_flag, test_on;
    logic [15:0]   frame_count;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr, level;
    logic          empty, full;

    logic          wr, push_req, ctrl_wr, clr, flush;
    logic          push, pop, ovf_set, unf_set;
    logic [23:0]   pix_rgb, bar_rgb;
    logic          unused_sig;

    assign unused_sig = ^{read, writedata[7:2]};

    assign pix_en  = (div_cnt == DIV_LAST);
    assign sof     = pix_en && (hcount == '0) && (vcount == '0);
    assign active  = (hcount < H_ACT) && (vcount < V_ACT);
    // enable_live is reloaded on the origin pixel itself, so that pixel already uses the new value
    assign en_now    = sof ? ctrl_enable : enable_live;
    assign pixel_due = pix_en && active && en_now;

    assign wr       = chipselect && write;
    assign push_req = wr && (address == 8'd0);
    assign ctrl_wr  = wr && (address == 8'd1);
    assign clr      = wr && (address == 8'd3) && writedata[0];
    assign flush    = wr && (address == 8'd3) && writedata[1];

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    assign pop     = pixel_due && !empty && !test_on;
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;
    assign unf_set = pixel_due && empty && !test_on;

`ifdef VGA_PIXEL_WRITER_TEST_PATTERN_EN
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
    logic          ctrl_test;
    logic [HW-1:0] bar_sel;

    assign test_on = ctrl_test;
    assign bar_sel = hcount / BAR_W;

    // Colour-bar lookup for the current horizontal position
    always_comb begin
        bar_rgb = '0;
        case (bar_sel)
            HW'(0):  bar_rgb = 24'hFFFFFF;
            HW'(1):  bar_rgb = 24'hFFFF00;
            HW'(2):  bar_rgb = 24'h00FFFF;
            HW'(3):  bar_rgb = 24'h00FF00;
            HW'(4):  bar_rgb = 24'hFF00FF;
            HW'(5):  bar_rgb = 24'hFF0000;
            HW'(6):  bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end
`else
    assign test_on = 1'b0;
    assign bar_rgb = '0;
`endif

    // Colour for the pixel at the current counters
    always_comb begin
        pix_rgb = '0;
        if (pixel_due) begin
            if (test_on)     pix_rgb = bar_rgb;
            else if (!empty) pix_rgb = mem[rd_ptr[AW-1:0]];
        end
    end

    // Pixel divider and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            hcount  <= '0;
            vcount  <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Registered video outputs, one pixel behind the counters
    always_ff @(posedge clk) begin
        if (reset) begin
            {VGA_R, VGA_G, VGA_B} <= '0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            BLANK_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= sof;
            if (pix_en) begin
                {VGA_R, VGA_G, VGA_B} <= pix_rgb;
                HSYNC   <= !((hcount >= HS_BEG) && (hcount < HS_END));
                VSYNC   <= !((vcount >= VS_BEG) && (vcount < VS_END));
                BLANK_n <= active;
            end
        end
    end

    // Control register, frame-synchronous enable, frame counter and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            enable_live <= 1'b0;
            frame_count <= '0;
            ovf_flag    <= 1'b0;
            unf_flag    <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_enable <= writedata[0];
            if (sof) begin
                enable_live <= ctrl_enable;
                frame_count <= frame_count + 16'd1;
            end
            if (ovf_set)  ovf_flag <= 1'b1;
            else if (clr) ovf_flag <= 1'b0;
            if (unf_set)  unf_flag <= 1'b1;
            else if (clr) unf_flag <= 1'b0;
        end
    end

`ifdef VGA_PIXEL_WRITER_TEST_PATTERN_EN
    // Test-pattern select bit
    always_ff @(posedge clk) begin
        if (reset)        ctrl_test <= 1'b0;
        else if (ctrl_wr) ctrl_test <= writedata[1];
    end
`endif

    // FIFO pointers; flush overrides any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LW'(1);
            if (pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= writedata[31:8];
    end

    // Register read mux
    always_comb begin
        readdata = '0;
        case (address)
            8'd1:    readdata = {30'd0, test_on, ctrl_enable};
            8'd2:    readdata = {frame_count, 5'd0, !(vcount < V_ACT), unf_flag, ovf_flag, 8'(level)};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Bench for vga_pixel_writer on a reduced raster; a queue-based reference model
// predicts every video output sample and every register read.
module tb_vga_pixel_writer;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int PD = 2;
    localparam int DEPTH = 16;
    localparam int FRAME = HT * VT * PD;
`ifdef VGA_PIXEL_WRITER_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk, reset, chipselect, write, read;
    logic [7:0]  address;
    logic [31:0] writedata, readdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        HSYNC, VSYNC, BLANK_n, frame_start;

    vga_pixel_writer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEPTH), .PIX_DIV(PD)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .BLANK_n(BLANK_n), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned k;
    logic [23:0] fq[$];
    bit          m_en, m_test, m_live, m_ovf, m_unf;
    logic [15:0] m_frames;
    logic [23:0] e_rgb;
    bit          e_hs, e_vs, e_blank, e_fs;
    int          mh, mv;
    bit          pix, sof, live, act, due, tp, popping, push_req, ovf_set, unf_set, clr, flush, cwr;

    function automatic logic [23:0] bar(int h);
        case (h / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic int cur_h();
        return (k / PD) % HT;
    endfunction

    function automatic int cur_v();
        return ((k / PD) / HT) % VT;
    endfunction

    // Model: one update per clock edge from the inputs held across that edge
    always @(posedge clk) begin
        if (reset) begin
            k = 0; fq.delete();
            m_en = 0; m_test = 0; m_live = 0; m_ovf = 0; m_unf = 0; m_frames = 0;
            e_rgb = 0; e_hs = 1; e_vs = 1; e_blank = 0; e_fs = 0;
        end else begin
            mh = cur_h(); mv = cur_v();
            pix  = (k % PD) == PD - 1;
            sof  = pix && mh == 0 && mv == 0;
            live = sof ? m_en : m_live;
            act  = mh < HA && mv < VA;
            tp   = TP && m_test;
            due  = pix && act && live;
            push_req = chipselect && write && address == 8'd0;
            cwr      = chipselect && write && address == 8'd1;
            clr      = chipselect && write && address == 8'd3 && writedata[0];
            flush    = chipselect && write && address == 8'd3 && writedata[1];
            popping  = due && !tp && fq.size() > 0;
            ovf_set  = push_req && fq.size() == DEPTH && !popping;
            unf_set  = due && !tp && fq.size() == 0;
            e_fs = sof;
            if (pix) begin
                if (!due)              e_rgb = 0;
                else if (tp)           e_rgb = bar(mh);
                else if (fq.size() > 0) e_rgb = fq[0];
                else                   e_rgb = 0;
                e_hs    = !(mh >= HA + HF && mh < HA + HF + HS);
                e_vs    = !(mv >= VA + VF && mv < VA + VF + VS);
                e_blank = act;
            end
            if (popping) void'(fq.pop_front());
            if (push_req && fq.size() < DEPTH) fq.push_back(writedata[31:8]);
            if (flush) fq.delete();
            if (ovf_set) m_ovf = 1; else if (clr) m_ovf = 0;
            if (unf_set) m_unf = 1; else if (clr) m_unf = 0;
            if (cwr) begin m_en = writedata[0]; m_test = TP && writedata[1]; end
            if (sof) m_frames = m_frames + 16'd1;
            m_live = live;
            k = k + 1;
        end
    end

    function automatic logic [31:0] exp_read(logic [7:0] a);
        case (a)
            8'd1: return {30'd0, m_test, m_en};
            8'd2: return {m_frames, 5'd0, cur_v() >= VA, m_unf, m_ovf, 8'(fq.size())};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        total++;
        assert ({VGA_R, VGA_G, VGA_B, HSYNC, VSYNC, BLANK_n, frame_start} ===
                {e_rgb, e_hs, e_vs, e_blank, e_fs}) else begin
            bad++;
            $error("FAIL pix k=%0d got=%h/%b%b%b%b exp=%h/%b%b%b%b", k,
                   {VGA_R, VGA_G, VGA_B}, HSYNC, VSYNC, BLANK_n, frame_start,
                   e_rgb, e_hs, e_vs, e_blank, e_fs);
        end
    endtask

    task automatic rd(logic [7:0] a);
        address = a; chipselect = 1; read = 1;
        #1;
        chk("read", readdata, exp_read(a));
        read = 0; chipselect = 0;
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        step();
        chipselect = 0; write = 0; writedata = $urandom;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin step(); n++; end while (frame_start !== 1'b1 && n < 2 * FRAME + 4);
        chk("wait_fs", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic wait_line(int line);
        int n = 0;
        while (cur_v() != line && n < 2 * FRAME) begin step(); n++; end
        chk("wait_line", cur_v(), line);
    endtask

    initial begin
        int fs_seen, last_fs, cyc, hs_low, vs_low, rgb_nz, n;
        logic [23:0] first_px;
        logic [31:0] r;
        reset = 1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
        repeat (3) step();
        chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("rst_sync", {29'd0, HSYNC, VSYNC, BLANK_n}, 32'd6);
        rd(8'd2);
        reset = 0;

        // T1: disabled output over two frames
        fs_seen = 0; last_fs = 0; cyc = 0; hs_low = 0; vs_low = 0; rgb_nz = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(); cyc++;
            if (frame_start === 1'b1) begin
                if (fs_seen == 1) begin
                    chk("fs_period", cyc - last_fs, FRAME);
                    chk("hs_low", hs_low, HS * PD * VT);
                    chk("vs_low", vs_low, VS * HT * PD);
                    chk("rgb_off", rgb_nz, 0);
                end
                fs_seen++; last_fs = cyc; hs_low = 0; vs_low = 0; rgb_nz = 0;
            end
            if (HSYNC === 1'b0) hs_low++;
            if (VSYNC === 1'b0) vs_low++;
            if ({VGA_R, VGA_G, VGA_B} !== 24'd0) rgb_nz++;
        end
        chk("fs_count", fs_seen >= 2, 1);

        // T2: four pixels then underflow
        wr(8'd0, 32'hFF000000); wr(8'd0, 32'h00FF0000);
        wr(8'd0, 32'h0000FF00); wr(8'd0, 32'h12345600);
        wr(8'd1, 32'd1);
        rd(8'd1);
        wait_fs();
        chk("t2_px0", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFF0000);
        for (int i = 0; i < HA * PD; i++) step();
        rd(8'd2);
        r = readdata;
        chk("t2_unf_lvl", {r[9], r[7:0]}, {1'b1, 8'd0});

        // T3: overflow, clear, flush
        wr(8'd1, 32'd0);
        wait_fs();
        for (int i = 0; i < 17; i++) wr(8'd0, $urandom);
        rd(8'd2);
        r = readdata;
        chk("t3_full", {r[8], r[7:0]}, {1'b1, 8'd16});
        wr(8'd3, 32'd1);
        rd(8'd2);
        r = readdata;
        chk("t3_clr", {30'd0, r[9:8]}, 32'd0);
        wr(8'd3, 32'd2);
        rd(8'd2);
        r = readdata;
        chk("t3_flush", r[7:0], 32'd0);

        // T4: enable mid-frame takes effect at next frame origin
        first_px = 24'($urandom);
        wr(8'd0, {first_px, 8'd0});
        for (int i = 0; i < 5; i++) wr(8'd0, $urandom);
        wait_line(3);
        wr(8'd1, 32'd1);
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            rd(8'd2); step(); n++;
        end
        chk("t4_fs", {31'd0, frame_start}, 32'd1);
        chk("t4_px0", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, first_px});

        // Randomised traffic with varying push pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 700; i++) begin
                int sel = $urandom_range(0, 99);
                int push_pct = (ph % 2 == 0) ? 70 : 15;
                if (sel < push_pct) wr(8'd0, $urandom);
                else if (sel < push_pct + 3) wr(8'd1, {$urandom_range(0, 1) == 0 ? 30'd0 : 30'h3FFFFFFF,
                                                       1'($urandom), 1'($urandom_range(0, 3) != 0)});
                else if (sel < push_pct + 5) wr(8'd3, 32'($urandom_range(0, 3)));
                else if (sel < push_pct + 7) wr(8'($urandom_range(4, 255)), $urandom);
                else if (sel < push_pct + 12) begin rd(8'($urandom_range(0, 5))); step(); end
                else step();
            end
            rd(8'd2);
        end

        // T5: reset in the middle of a line with data queued
        wr(8'd1, 32'd0);
        wait_fs();
        wr(8'd3, 32'd2);
        for (int i = 0; i < 5; i++) wr(8'd0, $urandom);
        n = 0;
        while (cur_h() != 10 && n < FRAME) begin step(); n++; end
        reset = 1;
        step();
        chk("t5_sync", {29'd0, HSYNC, VSYNC, BLANK_n}, 32'd6);
        rd(8'd2);
        r = readdata;
        chk("t5_lvl", r[7:0], 32'd0);
        reset = 0;
        n = 0;
        do begin step(); n++; end while (frame_start !== 1'b1 && n < 2 * PD + 2);
        chk("t5_first_fs", n, PD);

`ifdef VGA_PIXEL_WRITER_TEST_PATTERN_EN
        // T6: colour bars, FIFO untouched
        for (int i = 0; i < 3; i++) wr(8'd0, $urandom);
        wr(8'd1, 32'd3);
        wait_fs();
        chk("t6_px0", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);
        for (int i = 0; i < 2 * PD; i++) step();
        chk("t6_bar1", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
        for (int i = 0; i < (HA - 1 - 2) * PD; i++) step();
        chk("t6_last", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h000000);
        rd(8'd2);
        r = readdata;
        chk("t6_status", {r[9], r[7:0]}, {1'b0, 8'd3});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
